// File: rtl/node_pkg.sv
// Shared definitions for the node-sharing arbiter slice.
// State encodings and widths used by the arbiter and its picker.
package node_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int WD_W      = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } state_t;

endpackage

// File: rtl/node_share_arbiter_rr_pick.sv
// Round-robin priority encoder: first set request at or after ptr.
// Purely combinational; returns one-hot, index and valid.
module rr_pick
    import node_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [PW-1:0]   idx,
    output logic            valid
);

    always_comb begin
        int          j;
        logic [PW-1:0] jx;
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        j      = 0;
        jx     = '0;
        // Walk from farthest to nearest so the nearest hit wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            jx = PW'(j);
            if (req[jx]) begin
                onehot     = '0;
                onehot[jx] = 1'b1;
                idx        = jx;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/node_share_arbiter.sv
// Shares one start/ready operator node between NREQ requesters.
// Round-robin grant, operand latch, start handshake, watchdog abort.
module node_share_arbiter
    import node_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int TIMEOUT = 65535
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       REQ,
    input  logic [NREQ*WIDTH-1:0] OPA,
    input  logic [NREQ*WIDTH-1:0] OPB,
    output logic [NREQ-1:0]       GNT,
    output logic [NREQ-1:0]       DONE,
    output logic                  ERR,
    output logic [WIDTH-1:0]      RES_OUT,
    output logic                  BUSY,
    output logic                  N_RST,
    output logic                  N_ST,
    output logic [WIDTH-1:0]      N_IN0,
    output logic [WIDTH-1:0]      N_IN1,
    input  logic                  N_RD,
    input  logic [WIDTH-1:0]      N_RES
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     win;
    logic [PW-1:0]     ptr_adv;
    logic [NREQ-1:0]   gnt_q;
    logic [WD_W-1:0]   wd;
    logic              rd_q;
    logic              n_st_q;
    logic [WIDTH-1:0]  res_q;
    logic [WIDTH-1:0]  in0_q;
    logic [WIDTH-1:0]  in1_q;
    logic [NREQ-1:0]   pk_oh;
    logic [PW-1:0]     pk_idx;
    logic              pk_vld;
    logic              wd_hit;
    logic              rd_rise;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (REQ),
        .ptr    (ptr),
        .onehot (pk_oh),
        .idx    (pk_idx),
        .valid  (pk_vld)
    );

    assign wd_hit  = (wd == WD_LAST);
    assign rd_rise = N_RD & ~rd_q;
    assign ptr_adv = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (pk_vld && N_RD) state_nxt = S_START;
            end
            S_START: begin
                if (n_st_q && !N_RD) state_nxt = S_WAIT;
                else if (wd_hit)     state_nxt = S_ABORT;
            end
            S_WAIT: begin
                // A finished result beats a simultaneous watchdog expiry.
                if (rd_rise)     state_nxt = S_DONE;
                else if (wd_hit) state_nxt = S_ABORT;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ABORT: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= S_IDLE;
            ptr    <= '0;
            win    <= '0;
            gnt_q  <= '0;
            rd_q   <= 1'b1;
            n_st_q <= 1'b0;
            wd     <= '0;
            res_q  <= '0;
            in0_q  <= '0;
            in1_q  <= '0;
        end else begin
            state  <= state_nxt;
            rd_q   <= N_RD;
            n_st_q <= (state == S_START) && (state_nxt == S_START);
            if (state_nxt != state)
                wd <= '0;
            else if (state == S_START || state == S_WAIT)
                wd <= wd + 1'b1;
            if (state == S_IDLE && state_nxt == S_START) begin
                gnt_q <= pk_oh;
                win   <= pk_idx;
                in0_q <= OPA[int'(pk_idx)*WIDTH +: WIDTH];
                in1_q <= OPB[int'(pk_idx)*WIDTH +: WIDTH];
            end
            if (state == S_WAIT && state_nxt == S_DONE)
                res_q <= N_RES;
            if (state_nxt == S_ABORT)
                res_q <= '0;
            if (state == S_DONE || state == S_ABORT) begin
                gnt_q <= '0;
                ptr   <= ptr_adv;
            end
        end
    end

    assign GNT     = gnt_q;
    assign DONE    = (state == S_DONE || state == S_ABORT) ? gnt_q : '0;
    assign ERR     = (state == S_ABORT);
    assign BUSY    = (state != S_IDLE);
    assign N_RST   = RST | (state == S_ABORT);
    assign N_ST    = n_st_q;
    assign N_IN0   = in0_q;
    assign N_IN1   = in1_q;
    assign RES_OUT = res_q;

endmodule
